xbar_config_loader: RTL and testbench

Configuration writer for the tile's input crossbar: accepts a stream of per-output select values over a valid/ready handshake, stages them in a shadow register, and commits the complete set atomically onto the flat `io_mux_configs` bus that the crossbar consumes. It sits between the tile's configuration port and the crossbar. The crossbar therefore never sees a partially loaded selection set.

---
 rtl/xbar_config_loader.sv | 134 +++++++++++++
 tb/tb_xbar_config_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_config_loader.sv
// Crossbar select loader: NUM_OUTS beats fill a shadow set that is committed atomically to io_mux_configs.
// Latency: last beat to new config is 2 edges. Backpressure: io_cfg_ready high only while loading.
// Optional XBAR_CFG_READBACK_EN adds a registered per-output select readback port.
module xbar_config_loader #(
    parameter int NUM_INS  = 31,
    parameter int NUM_OUTS = 42,
    parameter int SEL_W    = 5,
    localparam int CNT_W   = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_cfg_start,
    input  logic                      io_cfg_valid,
    output logic                      io_cfg_ready,
    input  logic [SEL_W-1:0]          io_cfg_data,
    output logic                      io_busy,
    output logic                      io_cfg_done,
    output logic                      io_cfg_err,
`ifdef XBAR_CFG_READBACK_EN
    input  logic [CNT_W-1:0]          io_rd_idx,
    output logic [SEL_W-1:0]          io_rd_data,
`endif
    output logic [NUM_OUTS*SEL_W-1:0] io_mux_configs
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUTS - 1);
    // One extra bit so a limit of exactly 2^SEL_W does not wrap to zero.
    localparam logic [SEL_W:0]   IN_LIM   = (SEL_W + 1)'(NUM_INS);

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [NUM_OUTS-1:0][SEL_W-1:0]   shadow_q, shadow_d;
    logic [NUM_OUTS-1:0][SEL_W-1:0]   active_q, active_d;
    logic                             err_q, err_d;
    logic                             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_cfg_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // A restart wins over any beat presented in the same cycle.
                if (io_cfg_start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (io_cfg_valid) begin
                    shadow_d[count_q] = io_cfg_data;
                    if ({1'b0, io_cfg_data} >= IN_LIM) begin
                        err_d = 1'b1;
                    end
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (!err_q) begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign io_cfg_ready   = (state_q == ST_LOAD);
    assign io_busy        = (state_q != ST_IDLE);
    assign io_cfg_done    = done_q;
    assign io_cfg_err     = err_q;
    assign io_mux_configs = active_q;

`ifdef XBAR_CFG_READBACK_EN
    localparam logic [CNT_W:0] RD_LIM = (CNT_W + 1)'(NUM_OUTS);

    logic [SEL_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if ({1'b0, io_rd_idx} < RD_LIM) begin
            rd_data_d = active_q[io_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign io_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_xbar_config_loader.sv
// Bench for xbar_config_loader: transaction-level model compared every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_xbar_config_loader;
    localparam int NI = 31;
    localparam int NO = 42;
    localparam int SW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [SW-1:0] data = '0;
    logic          ready, busy, done, err;
    logic [NO*SW-1:0] cfg;
`ifdef XBAR_CFG_READBACK_EN
    logic [CW-1:0] rd_idx = '0;
    logic [SW-1:0] rd_data;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    xbar_config_loader #(.NUM_INS(NI), .NUM_OUTS(NO), .SEL_W(SW)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .io_cfg_start   (start),
        .io_cfg_valid   (valid),
        .io_cfg_ready   (ready),
        .io_cfg_data    (data),
        .io_busy        (busy),
        .io_cfg_done    (done),
        .io_cfg_err     (err),
`ifdef XBAR_CFG_READBACK_EN
        .io_rd_idx      (rd_idx),
        .io_rd_data     (rd_data),
`endif
        .io_mux_configs (cfg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: a load is a list of accepted beats; once NO beats arrive a commit follows one cycle later.
    int shadow_m[NO];
    int cfg_m[NO];
    bit loading_m = 1'b0;
    bit commit_m  = 1'b0;
    bit err_m     = 1'b0;
    bit done_m    = 1'b0;
    int n_m       = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (shadow_m[i]) begin
                shadow_m[i] = 0;
                cfg_m[i]    = 0;
            end
            loading_m = 1'b0;
            commit_m  = 1'b0;
            err_m     = 1'b0;
            done_m    = 1'b0;
            n_m       = 0;
        end else begin
            done_m = 1'b0;
            if (commit_m) begin
                commit_m = 1'b0;
                if (!err_m) begin
                    cfg_m  = shadow_m;
                    done_m = 1'b1;
                end
            end else if (start) begin
                loading_m = 1'b1;
                n_m       = 0;
                err_m     = 1'b0;
            end else if (loading_m && valid) begin
                shadow_m[n_m] = int'(data);
                if (int'(data) >= NI) err_m = 1'b1;
                n_m++;
                if (n_m == NO) begin
                    loading_m = 1'b0;
                    commit_m  = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_bus(input string name, input int exp[NO]);
        int bad;
        bad = -1;
        for (int k = NO - 1; k >= 0; k--) begin
            if (int'(cfg[k*SW +: SW]) != exp[k]) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s field %0d got %0d expected %0d", name, bad, cfg[bad*SW +: SW], exp[bad]);
        end
    endtask

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_vs_model", ready, loading_m);
            chk("busy_vs_model", busy, loading_m || commit_m);
            chk("done_vs_model", done, done_m);
            chk("err_vs_model", err, err_m);
            chk_bus("cfg_vs_model", cfg_m);
        end
    end

    int done_cnt = 0;
    int done_cyc = -1;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
    endtask

    task automatic beat(input int v);
        valid = 1'b1;
        data  = SW'(v);
        step();
        valid = 1'b0;
    endtask

    int pat[NO];
    int fives[NO];
    int zeros[NO];
    int s, last, dc0;

    initial begin
        foreach (pat[k]) begin
            pat[k]   = k % 31;
            fives[k] = 5;
            zeros[k] = 0;
        end
        repeat (2) step();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Idle with valid toggling: nothing moves.
        for (int i = 0; i < 10; i++) begin
            valid = (i % 2) == 1;
            data  = SW'(i);
            step();
        end
        valid = 1'b0;
        chk("idle_ready", ready, 0);
        chk("idle_busy", busy, 0);
        chk_bus("idle_cfg", zeros);

        // Full back-to-back load.
        dc0 = done_cnt;
        do_start(s);
        chk("ready_after_start", ready, 1);
        for (int k = 0; k < NO; k++) beat(k % 31);
        last = cyc;
        step();
        step();
        chk("full_done_edge", done_cyc, last + 1);
        chk("full_done_count", done_cnt, dc0 + 1);
        chk("full_field41_bits", cfg[209:205], 10);
        chk("model_field41", cfg_m[41], 10);
        chk_bus("full_cfg", pat);

`ifdef XBAR_CFG_READBACK_EN
        rd_idx = 6'd40;
        step();
        chk("readback_idx40", rd_data, 9);
        rd_idx = 6'd45;
        step();
        chk("readback_idx45", rd_data, 0);
`endif

        // Load with a stall between every beat.
        dc0 = done_cnt;
        do_start(s);
        for (int k = 0; k < NO; k++) begin
            beat(k % 31);
            if (k != NO - 1) step();
        end
        step();
        step();
        chk("stall_done_edge", done_cyc - s, 43 + 41);
        chk("stall_done_count", done_cnt, dc0 + 1);
        chk_bus("stall_cfg", pat);

        // Out-of-range select on beat 7.
        dc0 = done_cnt;
        do_start(s);
        for (int k = 0; k < NO; k++) begin
            beat((k == 7) ? 31 : 30 - (k % 31));
            if (k == 6) chk("err_before_beat7", err, 0);
            if (k == 7) chk("err_after_beat7", err, 1);
        end
        step();
        step();
        chk("err_sticky", err, 1);
        chk("err_no_done", done_cnt, dc0);
        chk_bus("err_cfg_kept", pat);
        do_start(s);
        chk("err_cleared_by_start", err, 0);

        // Restart mid-load; the beat alongside the restart is dropped.
        for (int k = 0; k < 20; k++) beat(3);
        start = 1'b1;
        valid = 1'b1;
        data  = SW'(3);
        step();
        start = 1'b0;
        valid = 1'b0;
        for (int k = 0; k < NO; k++) beat(5);
        step();
        step();
        chk_bus("restart_cfg", fives);

        // Asynchronous reset at beat 20.
        do_start(s);
        for (int k = 0; k < 20; k++) beat(7);
        rst_n = 1'b0;
        #1;
        chk_bus("async_reset_cfg", zeros);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ready", ready, 0);
        chk("async_reset_err", err, 0);
        chk("async_reset_done", done, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_reset_busy", busy, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
